// File: rtl/sram_log_controller.sv
// sram_log_controller
//   Upstream command generator for the SRAM word interface block. Incoming
//   16-bit samples are buffered in a small FIFO and drained as sequential
//   SRAM writes. Single-word readback requests are also serviced, and reads
//   take priority over writes. Runs on the posedge of CLK_48MHZ. The
//   interface runs on the negedge and reports busy on MEM_STATUS.
//
//   Build option:
//     LOG_WRAP_EN  defined   - after the write at 0x7FFFF the log keeps going
//                              from 0x00000 and overwrites the oldest data
//                  undefined - logging halts once LOG_FULL is set
module sram_log_controller #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic [15:0] SAMPLE_DATA,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    input  logic        RD_REQ,
    input  logic [18:0] RD_ADDR,
    output logic        RD_READY,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic [18:0] WR_PTR,
    output logic        LOG_FULL,
    output logic        ERROR,
    output logic [1:0]  MEM_CMD,
    output logic [17:0] MEM_ADDRESS,
    output logic        MEM_CHIP_SELECT,
    output logic [15:0] MEM_DATA,
    input  logic        MEM_STATUS,
    input  logic [15:0] MEM_DATA_READ
);

    localparam int DEPTH    = 2 ** FIFO_AW;
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W    = (TMO_BITS > 4) ? TMO_BITS : 4;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [15:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] fifo_wp;
    logic [FIFO_AW-1:0] fifo_rp;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [15:0]        fifo_head;

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_t             state;
    logic               op_is_read;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_expired;
    logic [18:0]        wr_ptr;
    logic               log_full;
    logic               error;
    logic               rd_pend;
    logic [18:0]        rd_addr;
    logic [15:0]        rd_data;
    logic               rd_valid;
    logic               rd_accept;
    logic               write_allowed;
    logic [1:0]         mem_cmd;
    logic [17:0]        mem_address;
    logic               mem_cs;
    logic [15:0]        mem_data;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (FIFO_AW+1)'(DEPTH));
    assign fifo_push  = SAMPLE_VALID && !fifo_full;
    assign fifo_head  = fifo_mem[fifo_rp];

`ifdef LOG_WRAP_EN
    assign write_allowed = 1'b1;
`else
    assign write_allowed = !log_full;
`endif

    assign rd_accept   = RD_REQ && !rd_pend;
    assign tmo_expired = (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));

    // A write is only launched when no read is waiting, so reads win ties.
    assign fifo_pop = (state == ST_IDLE) && !MEM_STATUS && !rd_pend &&
                      !fifo_empty && write_allowed;

    // FIFO storage; contents need no reset because the pointers gate them
    always_ff @(posedge CLK_48MHZ) begin
        if (fifo_push) begin
            fifo_mem[fifo_wp] <= SAMPLE_DATA;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wp <= fifo_wp + FIFO_AW'(1);
            end
            if (fifo_pop) begin
                fifo_rp <= fifo_rp + FIFO_AW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Command FSM: read latch, op launch, STATUS handshake, completion and timeout
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            op_is_read  <= 1'b0;
            tmo_cnt     <= '0;
            wr_ptr      <= '0;
            log_full    <= 1'b0;
            error       <= 1'b0;
            rd_pend     <= 1'b0;
            rd_addr     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            mem_cmd     <= CMD_IDLE;
            mem_address <= '0;
            mem_cs      <= 1'b0;
            mem_data    <= '0;
        end else begin
            rd_valid <= 1'b0;

            if (rd_accept) begin
                rd_pend <= 1'b1;
                rd_addr <= RD_ADDR;
            end

            case (state)
                ST_IDLE: begin
                    if (!MEM_STATUS) begin
                        if (rd_pend) begin
                            mem_address <= rd_addr[17:0];
                            mem_cs      <= rd_addr[18];
                            mem_cmd     <= CMD_READ;
                            op_is_read  <= 1'b1;
                            tmo_cnt     <= '0;
                            state       <= ST_ISSUE;
                        end else if (fifo_pop) begin
                            mem_data    <= fifo_head;
                            mem_address <= wr_ptr[17:0];
                            mem_cs      <= wr_ptr[18];
                            mem_cmd     <= CMD_WRITE;
                            op_is_read  <= 1'b0;
                            tmo_cnt     <= '0;
                            state       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (MEM_STATUS) begin
                        mem_cmd <= CMD_IDLE;
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        state   <= ST_WAIT_DONE;
                    end else if (tmo_expired) begin
                        mem_cmd <= CMD_IDLE;
                        error   <= 1'b1;
                        if (op_is_read) begin
                            rd_pend <= 1'b0;
                        end
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    if (!MEM_STATUS) begin
                        if (op_is_read) begin
                            rd_data  <= MEM_DATA_READ;
                            rd_valid <= 1'b1;
                            rd_pend  <= 1'b0;
                        end else begin
                            if (wr_ptr == '1) begin
                                log_full <= 1'b1;
                            end
                            wr_ptr <= wr_ptr + 19'd1;
                        end
                        state <= ST_IDLE;
                    end else if (tmo_expired) begin
                        // Aborted writes leave wr_ptr alone; aborted reads never pulse RD_VALID.
                        error <= 1'b1;
                        if (op_is_read) begin
                            rd_pend <= 1'b0;
                        end
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                default: begin
                    mem_cmd <= CMD_IDLE;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign SAMPLE_READY    = !fifo_full;
    assign RD_READY        = !rd_pend;
    assign RD_DATA         = rd_data;
    assign RD_VALID        = rd_valid;
    assign WR_PTR          = wr_ptr;
    assign LOG_FULL        = log_full;
    assign ERROR           = error;
    assign MEM_CMD         = mem_cmd;
    assign MEM_ADDRESS     = mem_address;
    assign MEM_CHIP_SELECT = mem_cs;
    assign MEM_DATA        = mem_data;

endmodule

// File: tb/tb_sram_log_controller.sv
// tb_sram_log_controller
//   Directed bench for sram_log_controller. A small SRAM interface model
//   answers on the negedge, raising STATUS for one clock per accepted op
//   unless stalled, and records every op it accepts. Build with
//   LOG_WRAP_EN defined to check the wrapping variant.
module tb_sram_log_controller;

    logic        CLK_48MHZ = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] SAMPLE_DATA = '0;
    logic        SAMPLE_VALID = 1'b0;
    logic        SAMPLE_READY;
    logic        RD_REQ = 1'b0;
    logic [18:0] RD_ADDR = '0;
    logic        RD_READY;
    logic [15:0] RD_DATA;
    logic        RD_VALID;
    logic [18:0] WR_PTR;
    logic        LOG_FULL;
    logic        ERROR;
    logic [1:0]  MEM_CMD;
    logic [17:0] MEM_ADDRESS;
    logic        MEM_CHIP_SELECT;
    logic [15:0] MEM_DATA;
    logic        MEM_STATUS = 1'b0;
    logic [15:0] MEM_DATA_READ = '0;

    sram_log_controller #(
        .FIFO_AW        (3),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .CLK_48MHZ       (CLK_48MHZ),
        .RESET           (RESET),
        .SAMPLE_DATA     (SAMPLE_DATA),
        .SAMPLE_VALID    (SAMPLE_VALID),
        .SAMPLE_READY    (SAMPLE_READY),
        .RD_REQ          (RD_REQ),
        .RD_ADDR         (RD_ADDR),
        .RD_READY        (RD_READY),
        .RD_DATA         (RD_DATA),
        .RD_VALID        (RD_VALID),
        .WR_PTR          (WR_PTR),
        .LOG_FULL        (LOG_FULL),
        .ERROR           (ERROR),
        .MEM_CMD         (MEM_CMD),
        .MEM_ADDRESS     (MEM_ADDRESS),
        .MEM_CHIP_SELECT (MEM_CHIP_SELECT),
        .MEM_DATA        (MEM_DATA),
        .MEM_STATUS      (MEM_STATUS),
        .MEM_DATA_READ   (MEM_DATA_READ)
    );

    always #10 CLK_48MHZ = ~CLK_48MHZ;

    typedef struct {
        logic [1:0]  cmd;
        logic        cs;
        logic [17:0] addr;
        logic [15:0] data;
    } op_t;

    op_t         ops[$];
    logic [15:0] mem [int];
    int          busy_left = 0;
    bit          stall = 1'b0;
    int          op_rd = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    // Interface model: accept an op on the negedge, busy for one clock
    always @(negedge CLK_48MHZ) begin
        int a;
        if (!RESET) begin
            MEM_STATUS = 1'b0;
            busy_left  = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) MEM_STATUS = 1'b0;
        end else if (MEM_CMD != 2'd0 && !stall) begin
            ops.push_back('{MEM_CMD, MEM_CHIP_SELECT, MEM_ADDRESS, MEM_DATA});
            a = int'({MEM_CHIP_SELECT, MEM_ADDRESS});
            if (MEM_CMD == 2'd2) begin
                mem[a] = MEM_DATA;
            end else if (mem.exists(a)) begin
                MEM_DATA_READ = mem[a];
            end else begin
                // preloaded readback word
                MEM_DATA_READ = (a == 32'h40005) ? 16'hBEEF : 16'h0000;
            end
            MEM_STATUS = 1'b1;
            busy_left  = 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; all driving and sampling happens 5 ns after posedge
    task automatic tick();
        @(posedge CLK_48MHZ);
        #5;
    endtask

    task automatic push(input logic [15:0] d);
        SAMPLE_DATA  = d;
        SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic wait_ops(input string tag, input int k);
        int n = 0;
        while (ops.size() < op_rd + k && n < 100) begin
            tick();
            n++;
        end
        chk({tag, ".ops"}, 32'(ops.size() - op_rd), 32'(k));
        repeat (3) tick();
    endtask

    task automatic next_op(input string tag, input logic [1:0] cmd, input logic [18:0] a,
                           input logic [15:0] d, input bit chk_data);
        chk({tag, ".present"}, 32'(ops.size() > op_rd), 32'(1));
        if (ops.size() > op_rd) begin
            chk({tag, ".cmd"},  32'(ops[op_rd].cmd),  32'(cmd));
            chk({tag, ".cs"},   32'(ops[op_rd].cs),   32'(a[18]));
            chk({tag, ".addr"}, 32'(ops[op_rd].addr), 32'(a[17:0]));
            if (chk_data) chk({tag, ".data"}, 32'(ops[op_rd].data), 32'(d));
            op_rd++;
        end
    endtask

    task automatic do_read(input string tag, input logic [18:0] a, input logic [15:0] exp);
        int pulses = 0;
        RD_REQ  = 1'b1;
        RD_ADDR = a;
        tick();
        RD_REQ = 1'b0;
        chk({tag, ".rd_ready_low"}, 32'(RD_READY), 32'(0));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (RD_VALID) pulses++;
        end
        chk({tag, ".pulses"},   32'(pulses),   32'(1));
        chk({tag, ".rd_data"},  32'(RD_DATA),  32'(exp));
        chk({tag, ".rd_ready"}, 32'(RD_READY), 32'(1));
        next_op(tag, 2'd1, a, 16'h0000, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".mem_cmd"},   32'(MEM_CMD),         32'(0));
        chk({tag, ".mem_addr"},  32'(MEM_ADDRESS),     32'(0));
        chk({tag, ".mem_cs"},    32'(MEM_CHIP_SELECT), 32'(0));
        chk({tag, ".mem_data"},  32'(MEM_DATA),        32'(0));
        chk({tag, ".rd_data"},   32'(RD_DATA),         32'(0));
        chk({tag, ".rd_valid"},  32'(RD_VALID),        32'(0));
        chk({tag, ".wr_ptr"},    32'(WR_PTR),          32'(0));
        chk({tag, ".log_full"},  32'(LOG_FULL),        32'(0));
        chk({tag, ".error"},     32'(ERROR),           32'(0));
        chk({tag, ".rd_ready"},  32'(RD_READY),        32'(1));
        chk({tag, ".smp_ready"}, 32'(SAMPLE_READY),    32'(1));
        chk({tag, ".fifo_cnt"},  32'(dut.fifo_cnt),    32'(0));
    endtask

    initial begin
        int accepted;
        int n;

        // Reset values
        #25;
        chk_reset_vals("rst");
        tick();
        RESET = 1'b1;
        tick();

        // Three sequential writes
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        wait_ops("wr3", 3);
        next_op("wr3.0", 2'd2, 19'h00000, 16'h1111, 1'b1);
        next_op("wr3.1", 2'd2, 19'h00001, 16'h2222, 1'b1);
        next_op("wr3.2", 2'd2, 19'h00002, 16'h3333, 1'b1);
        chk("wr3.wr_ptr",   32'(WR_PTR),       32'(3));
        chk("wr3.fifo_cnt", 32'(dut.fifo_cnt), 32'(0));
        chk("wr3.smp_rdy",  32'(SAMPLE_READY), 32'(1));

        // Readback from the upper half
        do_read("rb", 19'h40005, 16'hBEEF);

        // Read and push in the same clock; second request while busy is dropped
        RD_REQ       = 1'b1;
        RD_ADDR      = 19'h00001;
        SAMPLE_DATA  = 16'h4444;
        SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
        RD_ADDR      = 19'h00002;
        tick();
        RD_REQ = 1'b0;
        wait_ops("prio", 2);
        next_op("prio.rd", 2'd1, 19'h00001, 16'h0000, 1'b0);
        next_op("prio.wr", 2'd2, 19'h00003, 16'h4444, 1'b1);
        repeat (12) tick();
        chk("prio.extra",   32'(ops.size() - op_rd), 32'(0));
        chk("prio.rd_data", 32'(RD_DATA),            32'(16'h2222));
        chk("prio.wr_ptr",  32'(WR_PTR),             32'(4));

        // Handshake timeout on a write
        stall = 1'b1;
        push(16'h5555);
        n = 0;
        while (MEM_CMD != 2'd2 && n < 10) begin
            tick();
            n++;
        end
        chk("to.issued", 32'(MEM_CMD), 32'(2));
        repeat (14) tick();
        chk("to.err_early", 32'(ERROR),   32'(0));
        chk("to.cmd_held",  32'(MEM_CMD), 32'(2));
        tick();
        chk("to.error",    32'(ERROR),        32'(1));
        chk("to.cmd",      32'(MEM_CMD),      32'(0));
        chk("to.wr_ptr",   32'(WR_PTR),       32'(4));
        chk("to.state",    32'(dut.state),    32'(0));
        chk("to.fifo_cnt", 32'(dut.fifo_cnt), 32'(0));
        stall = 1'b0;
        repeat (4) tick();
        chk("to.no_op", 32'(ops.size() - op_rd), 32'(0));

        // End of log space
        force dut.wr_ptr = 19'h7FFFE;
        tick();
        release dut.wr_ptr;
        tick();
        chk("end.forced", 32'(WR_PTR), 32'(19'h7FFFE));
        push(16'hA001);
        push(16'hA002);
        push(16'hA003);
        push(16'hA004);
`ifdef LOG_WRAP_EN
        wait_ops("end", 4);
`else
        wait_ops("end", 2);
`endif
        repeat (12) tick();
        next_op("end.0", 2'd2, 19'h7FFFE, 16'hA001, 1'b1);
        next_op("end.1", 2'd2, 19'h7FFFF, 16'hA002, 1'b1);
        chk("end.log_full", 32'(LOG_FULL), 32'(1));
`ifdef LOG_WRAP_EN
        next_op("end.2", 2'd2, 19'h00000, 16'hA003, 1'b1);
        next_op("end.3", 2'd2, 19'h00001, 16'hA004, 1'b1);
        chk("end.wr_ptr",   32'(WR_PTR),       32'(2));
        chk("end.fifo_cnt", 32'(dut.fifo_cnt), 32'(0));
`else
        chk("end.wr_ptr",   32'(WR_PTR),       32'(0));
        chk("end.fifo_cnt", 32'(dut.fifo_cnt), 32'(2));
`endif
        chk("end.extra", 32'(ops.size() - op_rd), 32'(0));
        do_read("end.rb", 19'h7FFFF, 16'hA002);
        chk("end.err_sticky", 32'(ERROR), 32'(1));

        // FIFO fill against a stalled interface, then reset mid-operation
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        op_rd = ops.size();
        stall = 1'b1;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            SAMPLE_DATA  = 16'hB000 + 16'(i);
            SAMPLE_VALID = 1'b1;
            if (SAMPLE_READY) accepted++;
            tick();
        end
        SAMPLE_VALID = 1'b0;
        // eight held in the FIFO plus the one already launched
        chk("full.accepted", 32'(accepted),     32'(9));
        chk("full.smp_rdy",  32'(SAMPLE_READY), 32'(0));
        chk("full.fifo_cnt", 32'(dut.fifo_cnt), 32'(8));
        chk("full.cmd",      32'(MEM_CMD),      32'(2));
        chk("full.data",     32'(MEM_DATA),     32'(16'hB000));
        RD_REQ  = 1'b1;
        RD_ADDR = 19'h00123;
        tick();
        RD_REQ = 1'b0;
        chk("full.rd_pend", 32'(RD_READY), 32'(0));
        #3;
        RESET = 1'b0;
        #1;
        chk_reset_vals("midrst");
        stall = 1'b0;
        tick();
        RESET = 1'b1;
        repeat (6) tick();
        chk("post.cmd",   32'(MEM_CMD),             32'(0));
        chk("post.no_op", 32'(ops.size() - op_rd),  32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sram_log_controller.md
Name: sram_log_controller

Overview:
- Upstream command generator for the SRAM word interface block. It buffers incoming 16-bit sensor samples in a small FIFO and drains them as sequential SRAM writes.
- It also services single-word random readback requests.
- It drives the interface's CMD/ADDRESS/DATA/CHIP_SELECT lines and tracks its STATUS (busy) handshake.
- Runs on the posedge of CLK_48MHZ; the interface runs on the negedge.

Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW entries of 16 bits.
- TIMEOUT_CYCLES, 15: max clocks spent in ISSUE or WAIT_DONE before abort (4-bit counter minimum, width ≥ clog2(TIMEOUT_CYCLES+1)).

Ports:
- CLK_48MHZ  in  1  system clock, 48 MHz
- RESET  in  1  reset RESET, asynchronous, active-low
- SAMPLE_DATA  in  16  sample word to log
- SAMPLE_VALID  in  1  sample strobe; pushed when SAMPLE_VALID & SAMPLE_READY
- SAMPLE_READY  out  1  FIFO not full
- RD_REQ  in  1  readback request; accepted when RD_REQ & RD_READY
- RD_ADDR  in  19  linear word address {chip_select, addr[17:0]}
- RD_READY  out  1  no readback pending or in flight
- RD_DATA  out  16  readback word, held until next readback completes
- RD_VALID  out  1  one-clock pulse when RD_DATA updates
- WR_PTR  out  19  next linear write address
- LOG_FULL  out  1  sticky: log space exhausted/wrapped
- ERROR  out  1  sticky: handshake timeout occurred
- MEM_CMD  out  2  0 idle, 1 read, 2 write
- MEM_ADDRESS  out  18  linear address bits [17:0]
- MEM_CHIP_SELECT  out  1  linear address bit 18 (0 = D[15:0] half, 1 = D[31:16] half)
- MEM_DATA  out  16  write data
- MEM_STATUS  in  1  interface busy
- MEM_DATA_READ  in  16  interface read data

Behaviour:
- Reset values:
  - MEM_CMD=0, MEM_ADDRESS=0, MEM_CHIP_SELECT=0, MEM_DATA=0.
  - RD_DATA=0, RD_VALID=0, WR_PTR=0, LOG_FULL=0, ERROR=0, RD_READY=1.
  - FIFO empty, so SAMPLE_READY=1. State=IDLE.
- FIFO:
  - Push and pop in the same clock are legal; count is unchanged.
  - Push when full is ignored; SAMPLE_READY=0 blocks it.
- Read latch: an accepted RD_REQ stores RD_ADDR and sets rd_pend, so RD_READY=0. rd_pend clears when the read completes or aborts.
- State machine IDLE/ISSUE/WAIT_DONE; op_is_read records the op in flight.
- IDLE, with MEM_STATUS=0:
  - If rd_pend: drive the read address, MEM_CMD=1, go to ISSUE. Reads have priority over writes.
  - Else if FIFO non-empty and not (LOG_FULL and no wrap): pop the head into MEM_DATA, drive WR_PTR onto address/CS, MEM_CMD=2, go to ISSUE.
- ISSUE:
  - Hold MEM_CMD until MEM_STATUS=1 is sampled.
  - Then MEM_CMD=0 and go to WAIT_DONE.
- WAIT_DONE: on MEM_STATUS=0, the op is complete.
  - Write: WR_PTR += 1.
  - Read: RD_DATA <= MEM_DATA_READ, RD_VALID pulse, rd_pend cleared.
  - Return to IDLE. The next op may issue on the following clock.
- Timeout:
  - The counter resets on entry to ISSUE and counts in ISSUE and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: ERROR=1 (sticky), MEM_CMD=0, return to IDLE.
  - An aborted write is discarded and WR_PTR is unchanged. An aborted read clears rd_pend with no RD_VALID.
- MEM_ADDRESS, MEM_CHIP_SELECT and MEM_DATA stay stable from IDLE exit until return to IDLE.
- Write end: when the write at 0x7FFFF completes, LOG_FULL=1 and WR_PTR wraps to 0.
  - Without wrap enabled: no further writes; the FIFO fills and SAMPLE_READY drops. Reads still serviced.
- Reset mid-operation: all state is cleared immediately, MEM_CMD=0, the FIFO is flushed, and any pending read is lost.

Optional Feature:
- LOG_WRAP_EN defined: after LOG_FULL is set, writes continue from 0x00000, overwriting the oldest data. LOG_FULL is still set (sticky) on the first wrap.
- LOG_WRAP_EN undefined: logging halts at LOG_FULL as described above.

Test Plan:
- Push 3 samples 0x1111, 0x2222, 0x3333 with the bus model answering STATUS high 1 clk -> three MEM_CMD=2 ops at addresses 0, 1, 2 with matching MEM_DATA; WR_PTR=3; FIFO empty.
- Preload the model at linear 0x40005 with 0xBEEF; pulse RD_REQ with RD_ADDR=0x40005 -> MEM_CMD=1, MEM_CHIP_SELECT=1, MEM_ADDRESS=0x00005; RD_DATA=0xBEEF with a 1-clk RD_VALID; RD_READY back to 1.
- RD_REQ in the same clock as a FIFO push while IDLE -> read issued first, write next; the second RD_REQ while RD_READY=0 is ignored.
- Force WR_PTR near 0x7FFFE and push 4 samples -> 0x7FFFE and 0x7FFFF written, LOG_FULL=1. Without LOG_WRAP_EN: remaining 2 held in FIFO. With LOG_WRAP_EN: written at 0, 1.
- Model never raises STATUS -> after 15 clks ERROR=1, MEM_CMD=0, WR_PTR unchanged, controller back in IDLE.
- Push 9 samples while the model is stalled (depth 8) -> SAMPLE_READY=0 after 8; assert RESET low mid-op -> all outputs at reset values and FIFO empty.
